// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and constants: byte matrix layout, FSM states,
// round constants and the forward S-box.
package aes_pkg;

    localparam int NO_ROWS   = 4;
    localparam int NO_COLS   = 4;
    localparam int NO_ROUNDS = 10;

    localparam logic [3:0] LAST_ROUND = 4'(NO_ROUNDS);

    // [row][col][bit]; column c is key word w[c], row 0 is its most significant byte
    typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] byte_matrix_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_exp_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] k);
        case (k)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
// Purely combinational, no latency, no flow control.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [NO_ROWS-1:0][7:0] word,
    output logic [NO_ROWS-1:0][7:0] sub_word
);

    always_comb begin
        sub_word = '0;
        for (int r = 0; r < NO_ROWS; r++) begin
            sub_word[r] = sbox(word[r]);
        end
    end

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: one round key per cycle into an 11-entry table, served on request.
// Response one cycle after the key exists; requests for unwritten rounds wait as a single pending slot.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic                                   aes_clk,
    input  logic                                   reset,
    input  logic                                   key_load_i,
    input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]   cipher_key_i,
    input  logic                                   key_req_i,
    input  logic [3:0]                             key_sel_i,
    output logic                                   key_vld_o,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]   round_key_o,
    output logic                                   key_err_o,
    output logic                                   expand_busy_o,
    output logic                                   expand_done_o
);

    key_exp_state_t state, state_nxt;

    logic [3:0]         round_cnt;
    byte_matrix_t       cur_key;
    byte_matrix_t       next_key;
    byte_matrix_t       key_tbl [0:NO_ROUNDS];
    logic [NO_ROWS-1:0][7:0] rot_word;
    logic [NO_ROWS-1:0][7:0] sub_word;

    logic               pend_vld;
    logic [3:0]         pend_sel;
    logic               req_act;
    logic [3:0]         sel_eff;
    logic               have_key;
    logic [3:0]         avail;
    byte_matrix_t       src_key;
    logic               resp_vld;
    logic               resp_err;
    logic               pend_nxt;

    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_load_i) state_nxt = EXPAND;
            EXPAND:  if (!key_load_i && round_cnt == LAST_ROUND) state_nxt = READY;
            READY:   if (key_load_i) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        expand_busy_o = (state == EXPAND);
        expand_done_o = (state == READY);
    end

    always_comb begin
        rot_word = '0;
        for (int r = 0; r < NO_ROWS; r++) begin
            rot_word[r] = cur_key[(r + 1) % NO_ROWS][NO_COLS-1];
        end
    end

    aes_sub_word u_sub_word (
        .word     (rot_word),
        .sub_word (sub_word)
    );

    always_comb begin
        next_key = cur_key;
        for (int r = 0; r < NO_ROWS; r++) begin
            next_key[r][0] = cur_key[r][0] ^ sub_word[r] ^ ((r == 0) ? rcon(round_cnt) : 8'h00);
            for (int c = 1; c < NO_COLS; c++) begin
                next_key[r][c] = cur_key[r][c] ^ next_key[r][c-1];
            end
        end
    end

    // Requests are judged against the table as it will stand after this edge,
    // so a key being written now (or loaded now) is served without an extra cycle.
    always_comb begin
        req_act  = pend_vld || key_req_i;
        sel_eff  = pend_vld ? pend_sel : key_sel_i;
        have_key = 1'b1;
        avail    = LAST_ROUND;
        src_key  = key_tbl[sel_eff];
        if (key_load_i) begin
            avail   = 4'd0;
            src_key = cipher_key_i;
        end else begin
            case (state)
                IDLE:   have_key = 1'b0;
                EXPAND: begin
                    avail = round_cnt;
                    if (sel_eff == round_cnt) src_key = next_key;
                end
                default: ;
            endcase
        end

        resp_vld = 1'b0;
        resp_err = 1'b0;
        pend_nxt = 1'b0;
        if (req_act) begin
            if (sel_eff > LAST_ROUND || !have_key) resp_err = 1'b1;
            else if (sel_eff <= avail)             resp_vld = 1'b1;
            else                                   pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) begin
            round_cnt   <= 4'd0;
            cur_key     <= '0;
            for (int i = 0; i <= NO_ROUNDS; i++) key_tbl[i] <= '0;
            pend_vld    <= 1'b0;
            pend_sel    <= 4'd0;
            key_vld_o   <= 1'b0;
            key_err_o   <= 1'b0;
            round_key_o <= '0;
        end else begin
            if (key_load_i) begin
                key_tbl[0] <= cipher_key_i;
                cur_key    <= cipher_key_i;
                round_cnt  <= 4'd1;
            end else if (state == EXPAND) begin
                key_tbl[round_cnt] <= next_key;
                cur_key            <= next_key;
                if (round_cnt != LAST_ROUND) round_cnt <= round_cnt + 4'd1;
            end
            pend_vld  <= pend_nxt;
            pend_sel  <= sel_eff;
            key_vld_o <= resp_vld;
            key_err_o <= resp_err;
            if (resp_vld) round_key_o <= src_key;
        end
    end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed checks of the AES-128 key schedule against FIPS-197 Appendix A.1 vectors.
module tb_aes_key_expansion;
    import aes_pkg::*;

    logic         aes_clk = 1'b0;
    logic         reset;
    logic         key_load_i;
    byte_matrix_t cipher_key_i;
    logic         key_req_i;
    logic [3:0]   key_sel_i;
    logic         key_vld_o;
    byte_matrix_t round_key_o;
    logic         key_err_o;
    logic         expand_busy_o;
    logic         expand_done_o;

    aes_key_expansion dut (
        .aes_clk       (aes_clk),
        .reset         (reset),
        .key_load_i    (key_load_i),
        .cipher_key_i  (cipher_key_i),
        .key_req_i     (key_req_i),
        .key_sel_i     (key_sel_i),
        .key_vld_o     (key_vld_o),
        .round_key_o   (round_key_o),
        .key_err_o     (key_err_o),
        .expand_busy_o (expand_busy_o),
        .expand_done_o (expand_done_o)
    );

    always #5 aes_clk = ~aes_clk;

    int passed = 0;
    int total  = 0;
    logic [127:0] fips [0:10];
    logic [127:0] zero10;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge aes_clk);
        #1;
    endtask

    // Hex key string (w0 first) to [row][col] matrix.
    function automatic byte_matrix_t km(input logic [127:0] h);
        byte_matrix_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = h[127 - 8 * (4 * c + r) -: 8];
        return m;
    endfunction

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        reset        = 1'b1;
        key_load_i   = 1'b0;
        cipher_key_i = '0;
        key_req_i    = 1'b0;
        key_sel_i    = 4'd0;
        #12;
        check("rst_vld",  128'(key_vld_o), 128'(0));
        check("rst_err",  128'(key_err_o), 128'(0));
        check("rst_busy", 128'(expand_busy_o), 128'(0));
        check("rst_done", 128'(expand_done_o), 128'(0));
        check("rst_key",  round_key_o, 128'(0));
        @(negedge aes_clk);
        reset = 1'b0;
        tick;

        // request in IDLE with nothing loaded
        key_req_i = 1'b1; key_sel_i = 4'd0;
        tick;
        key_req_i = 1'b0;
        check("idle_err", 128'(key_err_o), 128'(1));
        check("idle_vld", 128'(key_vld_o), 128'(0));

        // round 1 requested right after load
        cipher_key_i = km(fips[0]); key_load_i = 1'b1;
        tick;
        key_load_i = 1'b0;
        check("t1_busy", 128'(expand_busy_o), 128'(1));
        check("t1_done", 128'(expand_done_o), 128'(0));
        key_req_i = 1'b1; key_sel_i = 4'd1;
        tick;
        key_req_i = 1'b0;
        check("t1_vld", 128'(key_vld_o), 128'(1));
        check("t1_key", round_key_o, km(fips[1]));

        // round 10 goes pending until its write edge
        key_load_i = 1'b1;
        tick;
        key_load_i = 1'b0;
        key_req_i = 1'b1; key_sel_i = 4'd10;
        tick;
        key_req_i = 1'b0;
        check("t2_pend_vld", 128'(key_vld_o), 128'(0));
        repeat (8) tick;
        check("t2_early_vld",  128'(key_vld_o), 128'(0));
        check("t2_early_done", 128'(expand_done_o), 128'(0));
        tick;
        check("t2_vld",  128'(key_vld_o), 128'(1));
        check("t2_key",  round_key_o, km(fips[10]));
        check("t2_done", 128'(expand_done_o), 128'(1));
        check("t2_busy", 128'(expand_busy_o), 128'(0));
        tick;
        check("t2_pulse", 128'(key_vld_o), 128'(0));
        check("t2_hold",  round_key_o, km(fips[10]));

        // back-to-back sweep over the full table
        key_req_i = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            key_sel_i = 4'(i);
            tick;
            check($sformatf("t3_vld%0d", i), 128'(key_vld_o), 128'(1));
            check($sformatf("t3_key%0d", i), round_key_o, km(fips[i]));
        end

        // out-of-range index in READY
        key_sel_i = 4'd11;
        tick;
        key_req_i = 1'b0;
        check("t4_err",  128'(key_err_o), 128'(1));
        check("t4_vld",  128'(key_vld_o), 128'(0));
        check("t4_hold", round_key_o, km(fips[10]));
        tick;
        check("t4_pulse", 128'(key_err_o), 128'(0));

        // reload a zero key mid-expansion with round 10 pending
        key_load_i = 1'b1;
        tick;
        key_load_i = 1'b0;
        key_req_i = 1'b1; key_sel_i = 4'd10;
        tick;
        key_req_i = 1'b0;
        repeat (3) tick;
        cipher_key_i = '0; key_load_i = 1'b1;
        tick;
        key_load_i = 1'b0;
        check("t5_busy", 128'(expand_busy_o), 128'(1));
        check("t5_done", 128'(expand_done_o), 128'(0));
        repeat (9) tick;
        check("t5_early_vld", 128'(key_vld_o), 128'(0));
        tick;
        check("t5_vld", 128'(key_vld_o), 128'(1));
        check("t5_key", round_key_o, km(zero10));

        // load and request together: the new key itself is returned
        cipher_key_i = km(fips[0]); key_load_i = 1'b1;
        key_req_i = 1'b1; key_sel_i = 4'd0;
        tick;
        key_load_i = 1'b0; key_req_i = 1'b0;
        check("ld_req_vld", 128'(key_vld_o), 128'(1));
        check("ld_req_key", round_key_o, km(fips[0]));

        // asynchronous reset mid-expansion drops the pending request
        key_req_i = 1'b1; key_sel_i = 4'd10;
        tick;
        key_req_i = 1'b0;
        tick;
        #2 reset = 1'b1;
        #1;
        check("t6_busy", 128'(expand_busy_o), 128'(0));
        check("t6_done", 128'(expand_done_o), 128'(0));
        check("t6_vld",  128'(key_vld_o), 128'(0));
        check("t6_key",  round_key_o, 128'(0));
        @(negedge aes_clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                tick;
                seen += int'(key_vld_o);
            end
            check("t6_dropped", 128'(seen), 128'(0));
        end
        key_req_i = 1'b1; key_sel_i = 4'd0;
        tick;
        key_req_i = 1'b0;
        check("t6_err", 128'(key_err_o), 128'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
